// File: rtl/clock_7seg_scanner.sv
// clock_7seg_scanner: time-multiplexed 7-segment scanner for the clock display.
// Latches a snapshot of the time fields once per frame, converts each field
// to segment codes and scans one digit per slot with leading blank cycles.
// Optional feature macro: BRIGHTNESS_PWM_EN (adds i_brightness, PWM dimming
// inside the lit part of each slot).

// Per-field decoder: binary 0..59 to tens/units segment codes, dash if out of range.
module seg_field_dec (
  input  logic [5:0] val,
  input  logic       oor,
  output logic [6:0] seg_tens,
  output logic [6:0] seg_units
);

  localparam logic [6:0] SEG_DASH = 7'h40;

  logic [2:0] tens;
  logic [3:0] units;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  // Split 0..59 into BCD digits with a compare chain (no divider).
  always_comb begin
    tens = 3'd0;
    for (int k = 1; k < 6; k++)
      if (val >= 6'(10 * k)) tens = 3'(k);
    units = 4'(val - 6'(tens) * 6'd10);
  end

  // Pick digit glyphs, or dashes for an invalid field.
  always_comb begin
    seg_tens  = seg7({1'b0, tens});
    seg_units = seg7(units);
    if (oor) begin
      seg_tens  = SEG_DASH;
      seg_units = SEG_DASH;
    end
  end

endmodule

module clock_7seg_scanner #(
  parameter int NUM_DIGITS   = 6,
  parameter int REFRESH_DIV  = 1000,
  parameter int BLANK_CYCLES = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [4:0]            i_hours,
  input  logic [5:0]            i_minutes,
  input  logic [5:0]            i_seconds,
  input  logic [NUM_DIGITS-1:0] i_dp,
  input  logic                  i_mode_12h,
  input  logic                  i_lz_blank,
`ifdef BRIGHTNESS_PWM_EN
  input  logic [3:0]            i_brightness,
`endif
  output logic [7:0]            o_7seg,
  output logic [NUM_DIGITS-1:0] o_digit_en,
  output logic                  o_frame_start
);

  localparam int NF = NUM_DIGITS / 2;
  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_C = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

  if (!(NUM_DIGITS == 4 || NUM_DIGITS == 6)) begin : g_bad_digits
    $error("clock_7seg_scanner: NUM_DIGITS must be 4 or 6");
  end
  if (REFRESH_DIV < 2) begin : g_bad_div
    $error("clock_7seg_scanner: REFRESH_DIV must be >= 2");
  end
  if (BLANK_CYCLES < 1 || BLANK_CYCLES >= REFRESH_DIV) begin : g_bad_blank
    $error("clock_7seg_scanner: BLANK_CYCLES out of range");
  end

  typedef struct packed {
    logic [4:0]            hours;
    logic [5:0]            minutes;
    logic [5:0]            seconds;
    logic [NUM_DIGITS-1:0] dp;
    logic                  mode_12h;
    logic                  lz_blank;
`ifdef BRIGHTNESS_PWM_EN
    logic [3:0]            brightness;
`endif
  } snap_t;

  logic [CW-1:0] cnt, cnt_nxt;
  logic [IW-1:0] idx, idx_nxt;
  logic          take;
  snap_t         snap, snap_in;

  logic [4:0]    hdisp;
  logic          h_oor, pm, lz_zero, lit;
  logic [7:0]    seg_nxt;
  logic [NUM_DIGITS-1:0] den_nxt;

  logic [NF-1:0][5:0]         fval;
  logic [NF-1:0]              foor;
  logic [NF-1:0][6:0]         seg_t, seg_u;
  logic [NUM_DIGITS-1:0][7:0] dig_byte;

  // Slot/digit counters; a snapshot is due when the scan re-enters slot 0 of digit 0.
  always_comb begin
    cnt_nxt = cnt + 1'b1;
    idx_nxt = idx;
    if (cnt == CNT_MAX) begin
      cnt_nxt = '0;
      idx_nxt = (idx == IDX_MAX) ? '0 : idx + 1'b1;
    end
    take = (cnt_nxt == '0) && (idx_nxt == '0);
  end

  // Gather the live inputs into snapshot form.
  always_comb begin
    snap_in          = '0;
    snap_in.hours    = i_hours;
    snap_in.minutes  = i_minutes;
    snap_in.seconds  = i_seconds;
    snap_in.dp       = i_dp;
    snap_in.mode_12h = i_mode_12h;
    snap_in.lz_blank = i_lz_blank;
`ifdef BRIGHTNESS_PWM_EN
    snap_in.brightness = i_brightness;
`endif
  end

  // Hours: range check, 12 h conversion, PM flag and leading-zero detect.
  always_comb begin
    h_oor = snap.hours > 5'd23;
    hdisp = snap.hours;
    if (snap.mode_12h) begin
      if (snap.hours == 5'd0)      hdisp = 5'd12;
      else if (snap.hours > 5'd12) hdisp = snap.hours - 5'd12;
    end
    pm      = snap.mode_12h && (snap.hours >= 5'd12) && !h_oor;
    lz_zero = snap.lz_blank && !h_oor && (hdisp < 5'd10);
  end

  // One decoder per time field: hours, minutes and (6-digit build) seconds.
  for (genvar f = 0; f < NF; f++) begin : g_field
    if (f == 0) begin : g_hr
      assign fval[f] = {1'b0, hdisp};
      assign foor[f] = h_oor;
    end else if (f == 1) begin : g_min
      assign fval[f] = snap.minutes;
      assign foor[f] = snap.minutes > 6'd59;
    end else begin : g_sec
      assign fval[f] = snap.seconds;
      assign foor[f] = snap.seconds > 6'd59;
    end
    seg_field_dec u_dec (
      .val      (fval[f]),
      .oor      (foor[f]),
      .seg_tens (seg_t[f]),
      .seg_units(seg_u[f])
    );
  end

  if (NF == 2) begin : g_no_sec
    logic unused_sec;
    assign unused_sec = ^snap.seconds;
  end

  // Assemble the full byte for each digit: glyph, lz blanking, dp and PM.
  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_digit
    logic [6:0] seg_raw, seg_lit;
    logic       dp_bit;
    if (d % 2 == 1) begin : g_units
      assign seg_raw = seg_u[d/2];
    end else begin : g_tens
      assign seg_raw = seg_t[d/2];
    end
    if (d == 0) begin : g_lz
      assign seg_lit = lz_zero ? 7'h00 : seg_raw;
    end else begin : g_nolz
      assign seg_lit = seg_raw;
    end
    if (d == NUM_DIGITS - 1) begin : g_pm
      assign dp_bit = snap.dp[d] | pm;
    end else begin : g_nopm
      assign dp_bit = snap.dp[d];
    end
    assign dig_byte[d] = {dp_bit, seg_lit};
  end

  // Next-cycle outputs, driven from the next cnt/idx so the pins are registered.
  // The snapshot edge always lands on cnt=0, which is blanked, so the lit
  // cycles only ever see the already-latched snapshot.
  always_comb begin
    seg_nxt = '0;
    den_nxt = '0;
    lit     = cnt_nxt >= BLANK_C;
`ifdef BRIGHTNESS_PWM_EN
    lit     = lit && (4'(cnt_nxt) <= snap.brightness);
`endif
    if (lit) begin
      den_nxt = NUM_DIGITS'(1) << idx_nxt;
      seg_nxt = dig_byte[idx_nxt];
    end
  end

  // Scan state, snapshot and output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt           <= CNT_MAX;
      idx           <= IDX_MAX;
      snap          <= '0;
      o_7seg        <= '0;
      o_digit_en    <= '0;
      o_frame_start <= 1'b0;
    end else begin
      cnt           <= cnt_nxt;
      idx           <= idx_nxt;
      if (take) snap <= snap_in;
      o_frame_start <= take;
      o_digit_en    <= den_nxt;
      o_7seg        <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_clock_7seg_scanner.sv
// tb_clock_7seg_scanner: directed frames with hand-computed digit bytes,
// queued per lit cycle and checked by an independent monitor.
module tb_clock_7seg_scanner;

  localparam int ND    = 6;
  localparam int RD    = 8;
  localparam int BC    = 2;
  localparam int FRAME = ND * RD;

  logic          clk = 1'b0;
  logic          i_rst = 1'b1;
  logic [4:0]    i_hours = '0;
  logic [5:0]    i_minutes = '0;
  logic [5:0]    i_seconds = '0;
  logic [ND-1:0] i_dp = '0;
  logic          i_mode_12h = 1'b0;
  logic          i_lz_blank = 1'b0;
  logic [3:0]    i_brightness = 4'hF;
  logic [7:0]    o_7seg;
  logic [ND-1:0] o_digit_en;
  logic          o_frame_start;

  always #5 clk = ~clk;

  clock_7seg_scanner #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_hours      (i_hours),
    .i_minutes    (i_minutes),
    .i_seconds    (i_seconds),
    .i_dp         (i_dp),
    .i_mode_12h   (i_mode_12h),
    .i_lz_blank   (i_lz_blank),
`ifdef BRIGHTNESS_PWM_EN
    .i_brightness (i_brightness),
`endif
    .o_7seg       (o_7seg),
    .o_digit_en   (o_digit_en),
    .o_frame_start(o_frame_start)
  );

  typedef struct {
    logic [ND-1:0] den;
    logic [7:0]    seg;
    int            pos;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  logic timed_out = 1'b0;
  logic end_req = 1'b0;
  logic done = 1'b0;
  logic rst_d = 1'b1;

  // Reset as seen by the DUT on the last edge.
  always @(posedge clk) rst_d <= i_rst;

  task automatic set_in(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s,
                        input logic [ND-1:0] dp, input logic m12, input logic lz);
    i_hours = h; i_minutes = m; i_seconds = s; i_dp = dp; i_mode_12h = m12; i_lz_blank = lz;
  endtask

  // One frame of expectations: every lit cycle of every digit slot.
  task automatic push_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5);
    logic [7:0] b [ND];
    exp_t e;
    b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3; b[4] = b4; b[5] = b5;
    for (int d = 0; d < ND; d++)
      for (int c = BC; c < RD; c++) begin
        e.den = ND'(1) << d;
        e.seg = b[d];
        e.pos = d * RD + c;
        exp_q.push_back(e);
      end
  endtask

  task automatic wait_fs();
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge clk);
      if (o_frame_start === 1'b1) return;
    end
    timed_out = 1'b1;
  endtask

  task automatic wait_den(input logic [ND-1:0] want);
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (o_digit_en === want) return;
    end
    timed_out = 1'b1;
  endtask

  // Monitor: reset state, frame timing, and queued lit-cycle contents.
  int   pos = 0;
  logic have_frame = 1'b0;
  logic was_rst = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst_d) begin
      checks++;
      if (o_digit_en !== '0 || o_7seg !== '0 || o_frame_start !== 1'b0) begin
        errors++;
        $display("FAIL reset_state: den=%b seg=%h fs=%b, required den=0 seg=00 fs=0",
                 o_digit_en, o_7seg, o_frame_start);
      end
      have_frame = 1'b0;
      was_rst = 1'b1;
    end else begin
      if (was_rst) begin
        checks++;
        if (o_frame_start !== 1'b1) begin
          errors++;
          $display("FAIL first_frame_start: fs=%b, required 1 in first cycle after release",
                   o_frame_start);
        end
      end
      was_rst = 1'b0;
      if (o_frame_start === 1'b1) begin
        if (have_frame) begin
          checks++;
          if (pos != FRAME - 1) begin
            errors++;
            $display("FAIL frame_period: got %0d cycles, required %0d", pos + 1, FRAME);
          end
        end
        pos = 0;
        have_frame = 1'b1;
      end else begin
        pos++;
      end
      if (o_digit_en !== '0) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_lit: den=%b seg=%h pos=%0d, required no lit cycle",
                   o_digit_en, o_7seg, pos);
        end else begin
          e = exp_q.pop_front();
          if (o_digit_en !== e.den || o_7seg !== e.seg || pos != e.pos) begin
            errors++;
            $display("FAIL lit_digit: den=%b seg=%h pos=%0d, required den=%b seg=%h pos=%0d",
                     o_digit_en, o_7seg, pos, e.den, e.seg, e.pos);
          end
        end
      end else begin
        checks++;
        if (o_7seg !== 8'h00) begin
          errors++;
          $display("FAIL blank_seg: seg=%h while digits off, required 00", o_7seg);
        end
      end
    end
    if (end_req && !done) begin
      checks++;
      if (timed_out) begin
        errors++;
        $display("FAIL wait_timeout: expected DUT event did not occur, required it within bound");
      end
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL queue_drain: %0d expected lit cycles not seen, required 0", exp_q.size());
      end
      done = 1'b1;
    end
  end

  initial begin
    // Frame 0: 24 h 12:30:59, snapshotted on the first edge after release.
    set_in(5'd12, 6'd30, 6'd59, 6'b000000, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    push_frame(8'h06, 8'h5B, 8'h4F, 8'h3F, 8'h6D, 8'h6F);
    #1 i_rst = 1'b0;
    wait_fs();

    // 12 h, midnight -> 12 AM, lz set but tens is 1.
    set_in(5'd0, 6'd30, 6'd59, 6'b000000, 1'b1, 1'b1);
    push_frame(8'h06, 8'h5B, 8'h4F, 8'h3F, 8'h6D, 8'h6F);
    wait_fs();

    // 12 h, 13:05:07 -> 1 PM with blanked hours tens.
    set_in(5'd13, 6'd5, 6'd7, 6'b000000, 1'b1, 1'b1);
    push_frame(8'h00, 8'h06, 8'h3F, 8'h6D, 8'h3F, 8'h87);
    wait_fs();

    // 24 h 12:30:59, then change inputs while digit 2 is lit.
    set_in(5'd12, 6'd30, 6'd59, 6'b000000, 1'b0, 1'b0);
    push_frame(8'h06, 8'h5B, 8'h4F, 8'h3F, 8'h6D, 8'h6F);
    wait_fs();
    wait_den(6'b000100);
    set_in(5'd23, 6'd15, 6'd30, 6'b000000, 1'b0, 1'b0);
    push_frame(8'h5B, 8'h4F, 8'h06, 8'h6D, 8'h4F, 8'h3F);
    wait_fs();

    // Minutes out of range with dp on digit 2.
    set_in(5'd12, 6'd60, 6'd59, 6'b000100, 1'b0, 1'b0);
    push_frame(8'h06, 8'h5B, 8'hC0, 8'h40, 8'h6D, 8'h6F);
    wait_fs();

    // 12 h 23:59:00 -> 11 PM, dp on first and last digit.
    set_in(5'd23, 6'd59, 6'd0, 6'b100001, 1'b1, 1'b1);
    push_frame(8'h86, 8'h06, 8'h6D, 8'h6F, 8'h3F, 8'hBF);
    wait_fs();

    // Hours and seconds out of range in 12 h: dashes, no PM.
    set_in(5'd25, 6'd0, 6'd63, 6'b000000, 1'b1, 1'b0);
    push_frame(8'h40, 8'h40, 8'h3F, 8'h3F, 8'h40, 8'h40);
    wait_fs();

    // 12 h noon -> 12 PM.
    set_in(5'd12, 6'd0, 6'd0, 6'b000000, 1'b1, 1'b1);
    push_frame(8'h06, 8'h5B, 8'h3F, 8'h3F, 8'h3F, 8'hBF);
    wait_fs();

    // Reset while digit 3 is lit; the rest of this frame never appears.
    wait_den(6'b001000);
    @(posedge clk); #1 i_rst = 1'b1;
    @(posedge clk); #1 exp_q.delete();
    repeat (2) @(posedge clk);
    push_frame(8'h06, 8'h5B, 8'h3F, 8'h3F, 8'h3F, 8'hBF);
    #1 i_rst = 1'b0;
    wait_fs();

    for (int i = 0; i < 2 * FRAME && exp_q.size() != 0; i++) @(negedge clk);
    end_req = 1'b1;
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
